// File: rtl/fde_pkg.sv
// Shared types and constants for the FDE CPU.
// Width parameters, opcode encodings and register-address type.
package fde_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;

    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] LS  = 4'b0100;
    localparam logic [3:0] RS  = 4'b1000;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/fde_scoreboard.sv
// Per-register busy flags and source-operand hazard detection.
// Claims from newly accepted instructions take priority over write-back clears.
module fde_scoreboard
    import fde_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_write_en,
    input  reg_addr_t       i_write_add,
    input  logic            i_rd_req,
    input  reg_addr_t       i_rd_add_1,
    input  reg_addr_t       i_rd_add_2,
    input  reg_addr_t       i_rd_dest,
    output logic            o_stall,
    output logic            o_accept,
    output logic [NREG-1:0] o_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            haz_1;
    logic            haz_2;

    always_comb begin
        haz_1 = busy_q[i_rd_add_1]
              && !(i_write_en && i_write_add == i_rd_add_1);
        haz_2 = busy_q[i_rd_add_2]
              && !(i_write_en && i_write_add == i_rd_add_2);
        o_stall  = i_rd_req && (haz_1 || haz_2);
        o_accept = i_rd_req && !o_stall;

        busy_d = busy_q;
        if (i_write_en && i_write_add != '0)
            busy_d[i_write_add] = 1'b0;
        // Set after clear: the claim belongs to the newer instruction.
        if (o_accept && i_rd_dest != '0)
            busy_d[i_rd_dest] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/fde_regfile.sv
// Architectural register file with write-back bypass and hazard stall.
// Operands are registered; valid one cycle after acceptance.
module fde_regfile
    import fde_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_write_en,
    input  logic [ADDR_W-1:0] i_write_add,
    input  logic [DATA_W-1:0] i_write_data,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_add_1,
    input  logic [ADDR_W-1:0] i_rd_add_2,
    input  logic [ADDR_W-1:0] i_rd_dest,
    output logic              o_stall,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_srcdata_1,
    output logic [DATA_W-1:0] o_srcdata_2,
    output logic [NREG-1:0]   o_busy
);

    data_t regs_q [NREG];
    data_t regs_d [NREG];
    logic  rd_valid_q;
    logic  rd_valid_d;
    data_t src_1_q;
    data_t src_1_d;
    data_t src_2_q;
    data_t src_2_d;
    logic  accept;
    logic  wr_ok;

    fde_scoreboard u_scoreboard (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_write_en  (i_write_en),
        .i_write_add (i_write_add),
        .i_rd_req    (i_rd_req),
        .i_rd_add_1  (i_rd_add_1),
        .i_rd_add_2  (i_rd_add_2),
        .i_rd_dest   (i_rd_dest),
        .o_stall     (o_stall),
        .o_accept    (accept),
        .o_busy      (o_busy)
    );

    function automatic data_t operand(input reg_addr_t a);
        if (a == '0)
            return '0;
        else if (i_write_en && i_write_add == a)
            return i_write_data;
        else
            return regs_q[a];
    endfunction

    always_comb begin
        wr_ok = i_write_en && i_write_add != '0;
        regs_d = regs_q;
        if (wr_ok)
            regs_d[i_write_add] = i_write_data;
        rd_valid_d = accept;
        src_1_d = src_1_q;
        src_2_d = src_2_q;
        if (accept) begin
            src_1_d = operand(i_rd_add_1);
            src_2_d = operand(i_rd_add_2);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            rd_valid_q <= 1'b0;
            src_1_q    <= '0;
            src_2_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            rd_valid_q <= rd_valid_d;
            src_1_q    <= src_1_d;
            src_2_q    <= src_2_d;
        end
    end

    assign o_rd_valid  = rd_valid_q;
    assign o_srcdata_1 = src_1_q;
    assign o_srcdata_2 = src_2_q;

endmodule

// File: tb/tb_fde_regfile.sv
// Directed bench for the register file and hazard scoreboard.
// Inputs change 1ns after posedge; stall sampled at negedge.
module tb_fde_regfile;
    import fde_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_write_en;
    logic [ADDR_W-1:0] i_write_add;
    logic [DATA_W-1:0] i_write_data;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_add_1;
    logic [ADDR_W-1:0] i_rd_add_2;
    logic [ADDR_W-1:0] i_rd_dest;
    logic              o_stall;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_srcdata_1;
    logic [DATA_W-1:0] o_srcdata_2;
    logic [NREG-1:0]   o_busy;

    int checks = 0;
    int fails  = 0;

    fde_regfile dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_write_en   (i_write_en),
        .i_write_add  (i_write_add),
        .i_write_data (i_write_data),
        .i_rd_req     (i_rd_req),
        .i_rd_add_1   (i_rd_add_1),
        .i_rd_add_2   (i_rd_add_2),
        .i_rd_dest    (i_rd_dest),
        .o_stall      (o_stall),
        .o_rd_valid   (o_rd_valid),
        .o_srcdata_1  (o_srcdata_1),
        .o_srcdata_2  (o_srcdata_2),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_write_en   = 1'b0;
        i_write_add  = '0;
        i_write_data = '0;
        i_rd_req     = 1'b0;
        i_rd_add_1   = '0;
        i_rd_add_2   = '0;
        i_rd_dest    = '0;
    endtask

    task automatic req(input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] d);
        i_rd_req   = 1'b1;
        i_rd_add_1 = a1;
        i_rd_add_2 = a2;
        i_rd_dest  = d;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] v);
        i_write_en   = 1'b1;
        i_write_add  = a;
        i_write_data = v;
    endtask

    task automatic test_reset();
        idle();
        i_reset = 1'b0;
        #3;
        checks++;
        if (o_busy !== 16'h0000 || o_rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_state busy=%h valid=%b want 0000/0",
                     o_busy, o_rd_valid);
        end
        checks++;
        if (o_srcdata_1 !== 8'h00 || o_srcdata_2 !== 8'h00) begin
            fails++;
            $display("FAIL reset_src got %h/%h want 00/00",
                     o_srcdata_1, o_srcdata_2);
        end
        step();
        step();
        i_reset = 1'b1;
        step();
    endtask

    task automatic test_first_read();
        req(3, 5, 7);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL first_stall got %b want 0", o_stall);
        end
        step();
        idle();
        checks++;
        if (o_rd_valid !== 1'b1 || o_srcdata_1 !== 8'h00
            || o_srcdata_2 !== 8'h00 || o_busy !== 16'h0080) begin
            fails++;
            $display("FAIL first_read v=%b s=%h/%h busy=%h want 1 00/00 0080",
                     o_rd_valid, o_srcdata_1, o_srcdata_2, o_busy);
        end
        step();
        checks++;
        if (o_rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL valid_drop got %b want 0", o_rd_valid);
        end
    endtask

    task automatic test_bypass();
        wr(7, 8'h2A);
        req(7, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL bypass_stall got %b want 0", o_stall);
        end
        step();
        idle();
        checks++;
        if (o_rd_valid !== 1'b1 || o_srcdata_1 !== 8'h2A
            || o_busy !== 16'h0000) begin
            fails++;
            $display("FAIL bypass v=%b s1=%h busy=%h want 1 2a 0000",
                     o_rd_valid, o_srcdata_1, o_busy);
        end
    endtask

    task automatic test_stall();
        req(7, 0, 4);
        step();
        checks++;
        if (o_srcdata_1 !== 8'h2A || o_busy !== 16'h0010) begin
            fails++;
            $display("FAIL stall_setup s1=%h busy=%h want 2a 0010",
                     o_srcdata_1, o_busy);
        end
        req(4, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clk);
            checks++;
            if (o_stall !== 1'b1) begin
                fails++;
                $display("FAIL stall_raw[%0d] got %b want 1", c, o_stall);
            end
            step();
            checks++;
            if (o_rd_valid !== 1'b0 || o_srcdata_1 !== 8'h2A) begin
                fails++;
                $display("FAIL stall_hold[%0d] v=%b s1=%h want 0 2a",
                         c, o_rd_valid, o_srcdata_1);
            end
        end
        wr(4, 8'h81);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL stall_release got %b want 0", o_stall);
        end
        step();
        idle();
        checks++;
        if (o_rd_valid !== 1'b1 || o_srcdata_1 !== 8'h81
            || o_busy !== 16'h0000) begin
            fails++;
            $display("FAIL stall_result v=%b s1=%h busy=%h want 1 81 0000",
                     o_rd_valid, o_srcdata_1, o_busy);
        end
    endtask

    task automatic test_waw();
        req(0, 0, 5);
        step();
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL waw_stall got %b want 0", o_stall);
        end
        step();
        idle();
        checks++;
        if (o_busy !== 16'h0020) begin
            fails++;
            $display("FAIL waw_busy got %h want 0020", o_busy);
        end
        wr(5, 8'h33);
        step();
        wr(6, 8'h5C);
        step();
        idle();
        req(6, 5, 0);
        step();
        idle();
        checks++;
        if (o_srcdata_1 !== 8'h5C || o_srcdata_2 !== 8'h33
            || o_busy !== 16'h0000) begin
            fails++;
            $display("FAIL waw_read s=%h/%h busy=%h want 5c/33 0000",
                     o_srcdata_1, o_srcdata_2, o_busy);
        end
    endtask

    task automatic test_same_src();
        req(6, 6, 0);
        step();
        idle();
        checks++;
        if (o_srcdata_1 !== 8'h5C || o_srcdata_2 !== 8'h5C) begin
            fails++;
            $display("FAIL same_src got %h/%h want 5c/5c",
                     o_srcdata_1, o_srcdata_2);
        end
    endtask

    task automatic test_r0();
        wr(0, 8'hFF);
        step();
        wr(0, 8'hFF);
        req(0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL r0_stall got %b want 0", o_stall);
        end
        step();
        idle();
        checks++;
        if (o_srcdata_1 !== 8'h00 || o_srcdata_2 !== 8'h00
            || o_busy[0] !== 1'b0 || o_rd_valid !== 1'b1) begin
            fails++;
            $display("FAIL r0_read s=%h/%h busy0=%b v=%b want 00/00 0 1",
                     o_srcdata_1, o_srcdata_2, o_busy[0], o_rd_valid);
        end
    endtask

    task automatic test_set_clear();
        req(0, 0, 2);
        wr(2, 8'h10);
        step();
        idle();
        checks++;
        if (o_busy !== 16'h0004) begin
            fails++;
            $display("FAIL setclr_busy got %h want 0004", o_busy);
        end
        checks++;
        if (dut.regs_q[2] !== 8'h10) begin
            fails++;
            $display("FAIL setclr_reg got %h want 10", dut.regs_q[2]);
        end
    endtask

    task automatic test_reset_mid();
        req(7, 0, 9);
        step();
        idle();
        checks++;
        if (o_busy !== 16'h0204 || o_rd_valid !== 1'b1
            || o_srcdata_1 !== 8'h2A) begin
            fails++;
            $display("FAIL rst_pre busy=%h v=%b s1=%h want 0204 1 2a",
                     o_busy, o_rd_valid, o_srcdata_1);
        end
        #2;
        i_reset = 1'b0;
        #1;
        checks++;
        if (o_busy !== 16'h0000 || o_rd_valid !== 1'b0
            || o_srcdata_1 !== 8'h00) begin
            fails++;
            $display("FAIL rst_async busy=%h v=%b s1=%h want 0000 0 00",
                     o_busy, o_rd_valid, o_srcdata_1);
        end
        step();
        i_reset = 1'b1;
        step();
        req(7, 4, 0);
        step();
        checks++;
        if (o_srcdata_1 !== 8'h00 || o_srcdata_2 !== 8'h00) begin
            fails++;
            $display("FAIL rst_r7r4 got %h/%h want 00/00",
                     o_srcdata_1, o_srcdata_2);
        end
        req(6, 2, 0);
        @(negedge i_clk);
        checks++;
        if (o_stall !== 1'b0) begin
            fails++;
            $display("FAIL rst_stall got %b want 0", o_stall);
        end
        step();
        idle();
        checks++;
        if (o_srcdata_1 !== 8'h00 || o_srcdata_2 !== 8'h00) begin
            fails++;
            $display("FAIL rst_r6r2 got %h/%h want 00/00",
                     o_srcdata_1, o_srcdata_2);
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_bypass();
        test_stall();
        test_waw();
        test_same_src();
        test_r0();
        test_set_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
